// File: rtl/dma_arb_pkg.sv
// Shared types for the DMA request arbiter: channel count, arbitration
// states and the 2-bit channel/priority index type.
package dma_arb_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        GRANT = 2'd2
    } arbState_t;

    typedef logic [1:0] chPrio_t;

    // Priority level of a channel relative to the channel currently on top.
    function automatic chPrio_t prio_of(input chPrio_t ch, input chPrio_t top);
        return ch - top;
    endfunction

endpackage

// File: rtl/dma_prio_encoder.sv
// Combinational priority encoder: scans channels from top upward (mod 4)
// and returns the first valid one, which is the lowest priority number.
module dma_prio_encoder
    import dma_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] validDreq_i,
    input  chPrio_t           top_i,
    output chPrio_t           winner_o,
    output logic              anyValid_o
);

    logic    found;
    chPrio_t cand;

    always_comb begin
        winner_o   = top_i;
        anyValid_o = |validDreq_i;
        found      = 1'b0;
        cand       = top_i;
        for (int p = 0; p < NUM_CH; p++) begin
            cand = top_i + chPrio_t'(p);
            if (!found && validDreq_i[cand]) begin
                winner_o = cand;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_request_arbiter.sv
// 8237A-style DMA request arbiter: qualifies DREQ, requests the bus with
// HRQ and holds a single DACK grant until the timing FSM signals completion.
module dma_request_arbiter
    import dma_arb_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [NUM_CH-1:0]      DREQ,
    input  logic                   HLDA,
    input  logic                   dreqActiveLow,
    input  logic                   dackActiveLow,
    input  logic                   rotatingPriority,
    input  logic [NUM_CH-1:0]      mask,
    input  logic                   ctrlDisable,
    input  logic                   serviceDone,
    output logic                   hrq,
    output logic [NUM_CH-1:0]      DACK,
    output logic [NUM_CH-1:0]      chSel,
    output logic [NUM_CH-1:0]      validDreq,
    output logic [NUM_CH-1:0][1:0] chPriority,
    output logic                   busy
);

    logic [NUM_CH-1:0] validDreq_q, validDreq_d;
    arbState_t         state_q, state_d;
    chPrio_t           top_q, top_d;
    chPrio_t           winner_q, winner_d;
    chPrio_t           encWinner;
    logic              anyValid;
    logic              granted;

    assign validDreq_d = (DREQ ^ {NUM_CH{dreqActiveLow}})
                       & ~mask
                       & ~{NUM_CH{ctrlDisable}};

    // Arbitration runs on the registered request flags so the decision in
    // REQ always reflects the validDreq value visible that cycle.
    dma_prio_encoder u_prio_enc (
        .validDreq_i (validDreq_q),
        .top_i       (top_q),
        .winner_o    (encWinner),
        .anyValid_o  (anyValid)
    );

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        case (state_q)
            IDLE: begin
                if (anyValid) state_d = REQ;
            end
            REQ: begin
                if (!anyValid) begin
                    state_d = IDLE;
                end else if (HLDA) begin
                    state_d  = GRANT;
                    winner_d = encWinner;
                end
            end
            GRANT: begin
                // Completion takes precedence over a simultaneous HLDA drop.
                if (serviceDone || !HLDA) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        top_d = top_q;
        if (!rotatingPriority) begin
            top_d = '0;
        end else if (state_q == GRANT && serviceDone) begin
            top_d = winner_q + 2'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            top_q       <= '0;
            winner_q    <= '0;
            validDreq_q <= '0;
        end else begin
            state_q     <= state_d;
            top_q       <= top_d;
            winner_q    <= winner_d;
            validDreq_q <= validDreq_d;
        end
    end

    assign granted   = (state_q == GRANT);
    assign hrq       = (state_q == REQ) || granted;
    assign busy      = (state_q != IDLE);
    assign validDreq = validDreq_q;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            chSel[i]      = granted && (winner_q == chPrio_t'(i));
            DACK[i]       = chSel[i] ^ dackActiveLow;
            chPriority[i] = prio_of(chPrio_t'(i), top_q);
        end
    end

endmodule

// File: doc/dma_request_arbiter.md
# dma_request_arbiter

Request-arbitration stage for the 4-channel 8237A-style DMA controller, directly upstream of the transfer-timing FSM. It qualifies raw DREQ pins against polarity, mask and controller-disable state, and raises HRQ toward the CPU. On HLDA it grants exactly one channel by fixed or rotating priority, and holds DACK until the timing FSM reports end of service. It exports per-channel valid-request flags, the one-hot channel select and the current 2-bit priority of each channel.

## Interface
- NUM_CH, 4, number of DMA channels; only 4 is supported.
- CLK  in  1  controller clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- DREQ  in  4  raw DMA request pins, polarity set by dreqActiveLow.
- HLDA  in  1  hold acknowledge from CPU, active-high.
- dreqActiveLow  in  1  1 = DREQ pins active-low.
- dackActiveLow  in  1  1 = DACK pins active-low.
- rotatingPriority  in  1  1 = rotating priority, 0 = fixed (ch0 highest).
- mask  in  4  per-channel mask; 1 blocks the request.
- ctrlDisable  in  1  command-register disable; blocks all requests.
- serviceDone  in  1  one-cycle pulse from the timing FSM: granted channel's service complete.
- hrq  out  1  hold request to CPU.
- DACK  out  4  acknowledge pins, polarity applied.
- chSel  out  4  one-hot granted channel, active-high; 0 when none.
- validDreq  out  4  registered qualified requests.
- chPriority  out  4x2  current priority per channel; 0 = highest.
- busy  out  1  high in any state other than IDLE.

## Operation
- validDreq[i] is registered each edge: (DREQ[i] ^ dreqActiveLow) & ~mask[i] & ~ctrlDisable.
- FSM states are IDLE, REQ and GRANT.
  - IDLE: if any validDreq, go to REQ.
  - REQ: hrq=1. If HLDA=1 and any validDreq, latch the winner and go to GRANT. If validDreq is all zero, go to IDLE and drop hrq. If HLDA=1 and validDreq=0, go to IDLE.
  - GRANT: hrq=1, chSel=one-hot(winner), DACK[winner] active. On serviceDone, go to IDLE and apply the rotation update. On HLDA=0 before serviceDone, abort to IDLE with no rotation.
- Winner selection: the valid channel with the numerically lowest chPriority. chPriority[i] = (i - top) mod 4, where top is a 2-bit register.
- Rotation: if rotatingPriority=1 when serviceDone is accepted, top <= winner+1 (mod 4), so the serviced channel becomes priority 3. If rotatingPriority=0, top is forced to 0 every cycle.
- The winner is latched on entry to GRANT. Later mask, DREQ or priority changes do not alter the grant.
- DACK[i] = (GRANT && winner==i) ^ dackActiveLow, combinational from registered state.

## Timing
- Reset values: state IDLE, top 0, validDreq 0, winner 0, hrq 0, chSel 0, busy 0, chPriority {0,1,2,3} for ch0..ch3, DACK = {4{dackActiveLow}}.
- Request latency: DREQ active at edge k gives validDreq=1 after k, then hrq=1 after k+1.
- Grant latency: HLDA sampled high at edge n gives DACK/chSel valid after n.
- Release: serviceDone at edge m gives hrq=0, DACK inactive and the rotated top, all after m.
- Back-to-back requests: at least one IDLE cycle between grants; hrq drops for at least one cycle.
- Simultaneous HLDA=1 and a request drop in REQ: the validDreq value of that cycle decides the outcome.
- serviceDone outside GRANT is ignored.
- Reset mid-GRANT: all outputs return to reset values immediately, asynchronously.

## Structure
- Package dma_arb_pkg holds:
  - NUM_CH = 4
  - typedef enum logic [1:0] {IDLE, REQ, GRANT} arbState_t
  - typedef logic [1:0] chPrio_t
- Sub-module dma_prio_encoder: combinational; inputs validDreq and top; outputs winner index and anyValid. It is instantiated once.

## Test plan
- Fixed priority: dreqActiveLow=0, DREQ=4'b1010, mask=0, HLDA raised 2 cycles after hrq -> chSel=4'b0010; on serviceDone, hrq=0 next cycle; chPriority remains {0,1,2,3}.
- Rotating priority: rotatingPriority=1, ch2 serviced -> chPriority becomes ch3=0, ch0=1, ch1=2, ch2=3. Next with DREQ=4'b0101 -> ch0 granted.
- Masking and disable: DREQ=4'b1111 with mask=4'b1111 or ctrlDisable=1 -> hrq stays 0 for 20 cycles. Unmasking ch3 -> hrq=1 two cycles later.
- Polarity: dreqActiveLow=1, dackActiveLow=1, DREQ=4'b1110 -> ch0 granted, DACK=4'b1110; at reset, DACK=4'b1111.
- Request withdrawal and abort: DREQ dropped while in REQ -> IDLE, hrq=0. HLDA dropped in GRANT -> IDLE, no rotation.
- Asynchronous reset during GRANT with rotating priority -> hrq=0, chSel=0 and top=0 without waiting for a clock edge.
